// File: rtl/ebus_xfer_ctl.sv
// EBUS transfer sequencer and CTL/PI arbiter for the EBOX.
// Optional odd-parity generation/checking is built when EBUS_PARITY_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | bus free; arbitrate and latch the winner's request
// S_SETUP   | select/function/data driven, demand low
// S_WAIT    | demand high, waiting for ebusXfer or the no-response timeout
// S_RELEASE | demand and drive dropped, done pulse to the granted requester
module ebus_xfer_ctl #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int DEV_W          = 7,
   parameter int PI_STREAK_MAX  = 2
) (
   input  logic             clk,
   input  logic             CROBAR,
   input  logic             ctlReq,
   input  logic [2:0]       ctlFunc,
   input  logic [DEV_W-1:0] ctlDev,
   input  logic [0:35]      ctlDataOut,
   output logic             ctlDone,
   input  logic             piReq,
   input  logic [2:0]       piFunc,
   input  logic [DEV_W-1:0] piDev,
   output logic             piDone,
   output logic [0:35]      rdData,
   output logic [DEV_W-1:0] ebusDS,
   output logic [2:0]       ebusFunc,
   output logic             ebusDemand,
   output logic [0:35]      ebusDataOut,
   output logic             ebusDriveEn,
   input  logic             ebusXfer,
   input  logic [0:35]      ebusDataIn,
`ifdef EBUS_PARITY_EN
   output logic             ebusParOut,
   input  logic             ebusParIn,
   output logic             parErr,
`endif
   output logic             timeoutErr
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int STK_W = (PI_STREAK_MAX > 0) ? $clog2(PI_STREAK_MAX + 1) : 1;
   localparam logic [STK_W-1:0] STK_MAX = STK_W'(PI_STREAK_MAX);
   localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETUP   = 2'd1,
      S_WAIT    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic             own_pi;
   logic [2:0]       func_q;
   logic [DEV_W-1:0] dev_q;
   logic [0:35]      data_q;
   logic [CNT_W-1:0] tmr;
   logic [STK_W-1:0] streak;
   logic             holdoff;
   logic [0:35]      rd_q;
   logic             tmo_q;
   logic             grant;
   logic             grant_pi;
   logic             bus_on;
   logic             drive_en;
`ifdef EBUS_PARITY_EN
   logic             par_q;
`endif

   always_comb begin
      state_nxt   = state;
      grant       = 1'b0;
      grant_pi    = 1'b0;
      bus_on      = (state == S_SETUP) || (state == S_WAIT);
      drive_en    = bus_on && func_q[2];
      ebusDS      = bus_on ? dev_q : '0;
      ebusFunc    = bus_on ? func_q : '0;
      ebusDriveEn = drive_en;
      ebusDataOut = drive_en ? data_q : '0;
      ebusDemand  = (state == S_WAIT);
      ctlDone     = (state == S_RELEASE) && !own_pi;
      piDone      = (state == S_RELEASE) && own_pi;
      case (state)
         S_IDLE: begin
            // holdoff skips the cycle right after done, when the last winner is still dropping req
            if (!holdoff && (piReq || ctlReq)) begin
               grant     = 1'b1;
               grant_pi  = piReq && (!ctlReq || (streak != STK_MAX));
               state_nxt = S_SETUP;
            end
         end
         S_SETUP:   state_nxt = S_WAIT;
         S_WAIT: begin
            if (ebusXfer || (tmr == '0)) state_nxt = S_RELEASE;
         end
         S_RELEASE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (CROBAR) begin
         state   <= S_IDLE;
         own_pi  <= 1'b0;
         func_q  <= '0;
         dev_q   <= '0;
         data_q  <= '0;
         tmr     <= '0;
         streak  <= '0;
         holdoff <= 1'b0;
         rd_q    <= '0;
         tmo_q   <= 1'b0;
`ifdef EBUS_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         holdoff <= (state == S_RELEASE);
         if (grant) begin
            own_pi <= grant_pi;
            func_q <= grant_pi ? piFunc : ctlFunc;
            dev_q  <= grant_pi ? piDev : ctlDev;
            data_q <= grant_pi ? '0 : ctlDataOut;
            tmo_q  <= 1'b0;
`ifdef EBUS_PARITY_EN
            par_q  <= 1'b0;
`endif
            if (grant_pi) begin
               if (streak != STK_MAX) streak <= streak + 1'b1;
            end else begin
               streak <= '0;
            end
         end
         if (state == S_SETUP) begin
            tmr <= TMR_LOAD;
         end else if (state == S_WAIT) begin
            tmr <= tmr - 1'b1;
            // acknowledge beats the terminal count when both land in the same cycle
            if (ebusXfer) begin
               if (!func_q[2]) begin
                  rd_q <= ebusDataIn;
`ifdef EBUS_PARITY_EN
                  if (!(^{ebusDataIn, ebusParIn})) par_q <= 1'b1;
`endif
               end
            end else if (tmr == '0) begin
               tmo_q <= 1'b1;
               if (!func_q[2]) rd_q <= '0;
            end
         end
      end
   end

   assign rdData     = rd_q;
   assign timeoutErr = tmo_q;
`ifdef EBUS_PARITY_EN
   assign ebusParOut = drive_en ? ~^data_q : 1'b0;
   assign parErr     = par_q;
`endif

endmodule

// File: tb/tb_ebus_xfer_ctl.sv
// Self-checking bench for ebus_xfer_ctl: directed plan cases, then random
// transfers scored against a cycle-count/arbitration model built from the bus rules.
module tb_ebus_xfer_ctl;

   localparam int TO   = 16;
   localparam int DW   = 7;
   localparam int SMAX = 2;

   logic          clk = 1'b0;
   logic          CROBAR;
   logic          ctlReq, piReq;
   logic [2:0]    ctlFunc, piFunc;
   logic [DW-1:0] ctlDev, piDev;
   logic [0:35]   ctlDataOut;
   logic          ctlDone, piDone;
   logic [0:35]   rdData;
   logic [DW-1:0] ebusDS;
   logic [2:0]    ebusFunc;
   logic          ebusDemand, ebusDriveEn;
   logic [0:35]   ebusDataOut;
   logic          ebusXfer;
   logic [0:35]   ebusDataIn;
   logic          timeoutErr;
`ifdef EBUS_PARITY_EN
   logic          ebusParOut, ebusParIn, parErr;
   assign ebusParIn = ~^ebusDataIn;
`endif

   int checks   = 0;
   int failures = 0;

   // reference model state
   int            streak_m;
   logic [35:0]   rd_m;
   bit            tmo_m;
   bit            pi_held, ctl_held;

   ebus_xfer_ctl #(.TIMEOUT_CYCLES(TO), .DEV_W(DW), .PI_STREAK_MAX(SMAX)) dut (
      .clk(clk), .CROBAR(CROBAR),
      .ctlReq(ctlReq), .ctlFunc(ctlFunc), .ctlDev(ctlDev), .ctlDataOut(ctlDataOut), .ctlDone(ctlDone),
      .piReq(piReq), .piFunc(piFunc), .piDev(piDev), .piDone(piDone),
      .rdData(rdData), .ebusDS(ebusDS), .ebusFunc(ebusFunc), .ebusDemand(ebusDemand),
      .ebusDataOut(ebusDataOut), .ebusDriveEn(ebusDriveEn), .ebusXfer(ebusXfer), .ebusDataIn(ebusDataIn),
`ifdef EBUS_PARITY_EN
      .ebusParOut(ebusParOut), .ebusParIn(ebusParIn), .parErr(parErr),
`endif
      .timeoutErr(timeoutErr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [35:0] rnd36();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[35:0];
   endfunction

   task automatic raise_ctl(input logic [2:0] f, input logic [DW-1:0] d, input logic [35:0] wd);
      ctlFunc = f; ctlDev = d; ctlDataOut = wd; ctlReq = 1'b1; ctl_held = 1'b1;
   endtask

   task automatic raise_pi(input logic [2:0] f, input logic [DW-1:0] d);
      piFunc = f; piDev = d; piReq = 1'b1; pi_held = 1'b1;
   endtask

   // Runs one transfer starting in an arbitration-eligible idle cycle.
   // delay = index of the WAIT cycle carrying ebusXfer; delay >= TO means no answer.
   task automatic do_xfer(input int delay, input logic [35:0] din, input bit keep,
                          output bit won_pi, output int lat);
      bit            w_pi, is_wr, exp_dem, exp_drv, exp_done;
      logic [2:0]    f;
      logic [DW-1:0] d;
      logic [35:0]   wd;
      int            n, bad;
      w_pi  = pi_held && (!ctl_held || streak_m != SMAX);
      f     = w_pi ? piFunc : ctlFunc;
      d     = w_pi ? piDev : ctlDev;
      wd    = w_pi ? 36'd0 : ctlDataOut;
      is_wr = f[2];
      n     = (delay < TO) ? delay + 1 : TO;
      streak_m = w_pi ? ((streak_m < SMAX) ? streak_m + 1 : SMAX) : 0;
      tmo_m = (delay >= TO);
      if (!is_wr) rd_m = tmo_m ? 36'd0 : din;
      bad    = 0;
      won_pi = 1'b0;
      lat    = -1;
      for (int cyc = 1; cyc <= n + 2; cyc++) begin
         step();
         exp_dem  = (cyc >= 2) && (cyc <= n + 1);
         exp_drv  = is_wr && (cyc <= n + 1);
         exp_done = (cyc == n + 2);
         if (ebusDemand !== exp_dem) bad++;
         if (ebusDriveEn !== exp_drv) bad++;
         if (exp_drv && (ebusDataOut !== wd)) bad++;
         if ((cyc <= n + 1) && ((ebusDS !== d) || (ebusFunc !== f))) bad++;
         if ((w_pi ? ctlDone : piDone) !== 1'b0) bad++;
         if ((w_pi ? piDone : ctlDone) !== exp_done) bad++;
         if (cyc == 1) chk("tmo_clear_on_grant", timeoutErr, 0);
         if (ctlDone || piDone) begin
            won_pi = piDone;
            if (lat < 0) lat = cyc;
         end
         if (cyc == 1) begin
            ebusXfer   = 1'($urandom_range(0, 1));
            ebusDataIn = rnd36();
         end else if (cyc <= n + 1) begin
            ebusXfer   = (cyc - 2 == delay);
            ebusDataIn = ebusXfer ? din : rnd36();
         end else begin
            ebusXfer = 1'b0;
            chk("rd_data", rdData, rd_m);
            chk("tmo_err", timeoutErr, tmo_m);
`ifdef EBUS_PARITY_EN
            chk("par_err", parErr, 0);
`endif
         end
      end
      step();
      if (!keep) begin
         if (w_pi) begin piReq = 1'b0; pi_held = 1'b0; end
         else      begin ctlReq = 1'b0; ctl_held = 1'b0; end
      end
      if (ctlDone || piDone || ebusDemand) bad++;
      if ((timeoutErr !== tmo_m) || (rdData !== rd_m)) bad++;
      chk("xfer_cycle_errors", bad, 0);
      step();
   endtask

   bit won;
   int lat, dly, r;
   bit exp_order [6] = '{1, 1, 0, 1, 1, 0};

   initial begin
      CROBAR = 1'b1; ctlReq = 0; piReq = 0; ctlFunc = 0; piFunc = 0; ctlDev = 0; piDev = 0;
      ctlDataOut = 0; ebusXfer = 0; ebusDataIn = 0;
      streak_m = 0; rd_m = 0; tmo_m = 0; pi_held = 0; ctl_held = 0;
      step(); step();
      chk("rst_done", {ctlDone, piDone}, 0);
      chk("rst_demand", ebusDemand, 0);
      chk("rst_drive", ebusDriveEn, 0);
      chk("rst_ds", ebusDS, 0);
      chk("rst_func", ebusFunc, 0);
      chk("rst_dout", ebusDataOut, 0);
      chk("rst_rd", rdData, 0);
      chk("rst_tmo", timeoutErr, 0);
      CROBAR = 1'b0;
      step();

      // CTL read, answer in second WAIT cycle
      raise_ctl(3'b000, 7'o014, 36'd0);
      do_xfer(1, 36'o123456701234, 0, won, lat);
      chk("read_lat", lat, 4);
      chk("read_data", rdData, 36'o123456701234);

      // CTL write
      raise_ctl(3'b100, 7'o020, 36'o777777000000);
      do_xfer(3, rnd36(), 0, won, lat);
      chk("write_lat", lat, 6);

      // no answer on a read, then the next grant clears the error
      raise_ctl(3'b001, 7'o044, 36'd0);
      do_xfer(TO + 5, rnd36(), 0, won, lat);
      chk("timeout_lat", lat, TO + 2);
      chk("timeout_rd", rdData, 0);
      // answer on the terminal-count cycle
      raise_ctl(3'b010, 7'o044, 36'd0);
      do_xfer(TO - 1, 36'o525252525252, 0, won, lat);
      chk("tc_race_lat", lat, TO + 2);
      chk("tc_race_rd", rdData, 36'o525252525252);

      // both requesters held continuously
      raise_pi(3'b011, 7'o001);
      raise_ctl(3'b000, 7'o002, 36'd0);
      for (int i = 0; i < 6; i++) begin
         do_xfer(0, rnd36(), 1, won, lat);
         chk("arb_order", won, exp_order[i]);
      end
      piReq = 0; ctlReq = 0; pi_held = 0; ctl_held = 0;
      step();

      // CROBAR during WAIT_XFER
      raise_ctl(3'b000, 7'o030, 36'd0);
      step(); step(); step();
      chk("crobar_pre_demand", ebusDemand, 1);
      CROBAR = 1'b1; ctlReq = 1'b0; ctl_held = 1'b0;
      step();
      chk("crobar_done", {ctlDone, piDone}, 0);
      chk("crobar_outs", {ebusDemand, ebusDriveEn, ebusDS, ebusFunc, timeoutErr}, 0);
      chk("crobar_rd", rdData, 0);
      CROBAR = 1'b0;
      streak_m = 0; rd_m = 0; tmo_m = 0;
      step();
      chk("crobar_idle", {ctlDone, piDone, ebusDemand}, 0);

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         if (!pi_held && !ctl_held) begin
            r = $urandom_range(0, 2);
            if (r != 1) raise_pi(3'($urandom), DW'($urandom));
            if (r != 0) raise_ctl(3'($urandom), DW'($urandom), rnd36());
         end else if ($urandom_range(0, 1) == 1) begin
            if (!pi_held) raise_pi(3'($urandom), DW'($urandom));
            else if (!ctl_held) raise_ctl(3'($urandom), DW'($urandom), rnd36());
         end
         r = $urandom_range(0, 9);
         dly = (r < 7) ? $urandom_range(0, 4) : (r == 7) ? TO - 1 : (r == 8) ? TO + 3 : TO - 2;
         begin
            bit exp_pi;
            exp_pi = pi_held && (!ctl_held || streak_m != SMAX);
            do_xfer(dly, rnd36(), 0, won, lat);
            chk("arb_rand", won, exp_pi);
            chk("lat_rand", lat, ((dly < TO) ? dly + 1 : TO) + 2);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ebus_xfer_ctl.md
Name: ebus_xfer_ctl

Overview:
- Sequences every EBUS transfer from the EBOX and arbitrates the bus between two requesters: CTL (DATAO/DATAI/CONO/CONI) and PI (interrupt function cycles).
- Drives the device select, function and demand lines, and waits for the device's transfer handshake.
- Returns read data, or flags a timeout if no device answers.
- Sits beside the CTL and PI blocks inside the EBOX, in front of the EBUS interface.

Parameters:
- TIMEOUT_CYCLES, 64, clk cycles allowed in WAIT_XFER before the no-response error; must be at least 2.
- DEV_W, 7, device-code width (IR bits 3:9).
- PI_STREAK_MAX, 2, consecutive PI grants allowed while CTL waits.

Ports:
- clk  in  1  EBOX clock.
- CROBAR  in  1  synchronous active-high reset.
- ctlReq  in  1  CTL transfer request; held until ctlDone.
- ctlFunc  in  3  CTL EBUS function code.
- ctlDev  in  DEV_W  CTL device code.
- ctlDataOut  in  36  [0:35] CTL write data.
- ctlDone  out  1  one-cycle pulse: CTL transfer finished.
- piReq  in  1  PI function-cycle request; held until piDone.
- piFunc  in  3  PI function code.
- piDev  in  DEV_W  PI device code.
- piDone  out  1  one-cycle pulse: PI transfer finished.
- rdData  out  36  [0:35] data captured on a read; valid with the done pulse.
- ebusDS  out  DEV_W  device select driven on EBUS.
- ebusFunc  out  3  function driven on EBUS.
- ebusDemand  out  1  EBUS demand.
- ebusDataOut  out  36  [0:35] EBUS write data.
- ebusDriveEn  out  1  EBOX drives ebusDataOut.
- ebusXfer  in  1  device transfer acknowledge.
- ebusDataIn  in  36  [0:35] device read data.
- timeoutErr  out  1  sticky no-response error; cleared by CROBAR or by a new grant.

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and the PI streak counter is 0.
- Read functions: func[2]=0. Write functions: func[2]=1. ebusDriveEn=1 only while a write is granted.
- IDLE:
  - If piReq and ctlReq are both asserted, PI wins unless streak==PI_STREAK_MAX; in that case CTL wins.
  - A PI grant increments the streak counter (saturating). A CTL grant clears it.
  - The winner's func, dev and data are latched, and the state moves to SETUP on the next edge. timeoutErr clears on the grant.
- SETUP (1 cycle): ebusDS, ebusFunc, ebusDataOut and ebusDriveEn are valid; ebusDemand=0. Next state is WAIT_XFER.
- WAIT_XFER: ebusDemand=1 and the timeout counter increments each cycle.
  - If ebusXfer=1: ebusDataIn is captured into rdData (reads only; rdData holds otherwise). The state moves to RELEASE.
  - Else if counter==TIMEOUT_CYCLES-1: timeoutErr is set, rdData becomes 0 for a read, and the state moves to RELEASE.
  - If ebusXfer and the terminal count occur in the same cycle, ebusXfer wins and no error is raised.
- RELEASE (1 cycle): ebusDemand=0 and ebusDriveEn=0. The done pulse for the granted requester fires, and the state returns to IDLE.
  - The requester must drop its req the cycle after done. A req still high two cycles after done is treated as a new request.
- Minimum transfer: grant→done = 3 cycles (SETUP, WAIT_XFER with immediate xfer, RELEASE).
- ebusXfer seen outside WAIT_XFER is ignored.
- A requester that drops req mid-transfer does not abort the transfer; its done pulse still fires.
- CROBAR mid-transfer: on the next edge the block returns to IDLE with all outputs 0 and no done pulse.

Optional Feature:
- Macro EBUS_PARITY_EN.
- When defined, adds:
  - output ebusParOut: odd parity over ebusDataOut, valid with ebusDriveEn.
  - input ebusParIn.
  - output parErr, sticky: set when a read transfer captures data whose odd parity with ebusParIn fails; cleared like timeoutErr.
- When undefined, these ports and parErr do not exist and no parity logic is built.

Test Plan:
- Single CTL read, device=7'o014, func=3'b000, ebusXfer in the 2nd WAIT_XFER cycle with data 36'o123456701234 -> rdData=36'o123456701234 and ctlDone pulses 4 cycles after the grant; ebusDriveEn stays 0 throughout.
- CTL write (func=3'b100) of 36'o777777000000 -> ebusDriveEn=1 and ebusDataOut constant from SETUP to the end of WAIT_XFER; ebusDemand low in SETUP, high in WAIT_XFER.
- piReq and ctlReq held high continuously -> grant order PI, PI, CTL, PI, PI, CTL.
- No ebusXfer on a read -> timeoutErr=1 and rdData=0, done fires after TIMEOUT_CYCLES cycles of demand; the next grant clears timeoutErr.
- ebusXfer arrives in the same cycle as the terminal count -> data captured, timeoutErr=0.
- CROBAR asserted during WAIT_XFER -> one edge later all outputs are 0, state is IDLE, and no done pulse fires.
